// File: rtl/mx_block_packer.sv
// ---------------------------------------------------------------------------
// mx_block_packer
//   Collects a stream of 8-bit MXFP8 elements plus one shared E8M0 scale per
//   block and packs them into a 264-bit MX block {scale, elem[31..0]}.
//   There is one assembly register and one output register. A new block can
//   therefore be filled while the previous block waits for the downstream
//   consumer.
//
// Optional feature (macro MX_PACK_FLUSH_EN):
//   Adds the flush input and the out_count output. A flush completes a
//   partial block early. Unfilled slots read as +0.0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   dtype_in   in   element format code, sampled with element 0
//   in_valid   in   element valid
//   in_ready   out  element can be accepted this cycle
//   in_elem    in   element payload (D bits)
//   in_scale   in   shared scale, sampled with element 0
//   out_valid  out  out_block holds a complete block
//   out_ready  in   downstream accepts the block
//   out_block  out  packed block (SIZE bits)
//   out_dtype  out  dtype of out_block
//   flush      in   (MX_PACK_FLUSH_EN) single-cycle early-completion request
//   out_count  out  (MX_PACK_FLUSH_EN) number of real elements in out_block
// ---------------------------------------------------------------------------
module mx_block_packer #(
    parameter int D    = 8,
    parameter int K    = 32,
    parameter int W    = 8,
    parameter int SIZE = K*D+W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      dtype_in,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [D-1:0]    in_elem,
    input  logic [W-1:0]    in_scale,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_block,
    output logic [2:0]      out_dtype
`ifdef MX_PACK_FLUSH_EN
    ,
    input  logic            flush,
    output logic [5:0]      out_count
`endif
);

    localparam logic [5:0] LAST_IDX = 6'(K-1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_r;
    logic [5:0]         count_r;
    logic [K*D-1:0]     slots_r;
    logic [W-1:0]       scale_r;
    logic [2:0]         dtype_r;

    logic               out_valid_r;
    logic [SIZE-1:0]    out_block_r;
    logic [2:0]         out_dtype_r;
`ifdef MX_PACK_FLUSH_EN
    logic [5:0]         out_count_r;
`endif

    logic               accept_s;
    logic               out_free_s;
    logic               flush_s;
    logic               complete_s;
    logic               load_s;
    logic [K*D-1:0]     slots_nxt_s;
    logic [W-1:0]       scale_nxt_s;
    logic [2:0]         dtype_nxt_s;
    logic [5:0]         fill_nxt_s;

    assign in_ready  = (state_r == ST_FILL);
    assign out_valid = out_valid_r;
    assign out_block = out_block_r;
    assign out_dtype = out_dtype_r;
`ifdef MX_PACK_FLUSH_EN
    assign out_count = out_count_r;
`endif

    // Next-state view of the assembly register and the load/complete decisions.
    // In HOLD no element is accepted. The "next" values then equal the held
    // block, so both load paths share the same source.
    always_comb begin
        accept_s    = in_valid && (state_r == ST_FILL);
        out_free_s  = !out_valid_r || out_ready;

        slots_nxt_s = slots_r;
        for (int i = 0; i < K; i++) begin
            if (accept_s && (count_r == 6'(i))) begin
                slots_nxt_s[i*D +: D] = in_elem;
            end else begin
                slots_nxt_s[i*D +: D] = slots_r[i*D +: D];
            end
        end

        if (accept_s && (count_r == 6'd0)) begin
            scale_nxt_s = in_scale;
            dtype_nxt_s = dtype_in;
        end else begin
            scale_nxt_s = scale_r;
            dtype_nxt_s = dtype_r;
        end

        fill_nxt_s = count_r + {5'd0, accept_s};

`ifdef MX_PACK_FLUSH_EN
        // A flush is honoured only when it would produce at least one element.
        flush_s = flush && (state_r == ST_FILL) && ((count_r != 6'd0) || accept_s);
`else
        flush_s = 1'b0;
`endif

        complete_s = (accept_s && (count_r == LAST_IDX)) || flush_s;
        load_s     = out_free_s && (complete_s || (state_r == ST_HOLD));
    end

    // Assembly register and fill state machine.
    // Slots are cleared on every hand-off. Slots past the fill count are
    // therefore always zero, and a flushed block needs no masking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FILL;
            count_r <= 6'd0;
            slots_r <= '0;
            scale_r <= '0;
            dtype_r <= 3'd0;
        end else begin
            scale_r <= scale_nxt_s;
            dtype_r <= dtype_nxt_s;
            if (load_s) begin
                state_r <= ST_FILL;
                count_r <= 6'd0;
                slots_r <= '0;
            end else if (complete_s) begin
                state_r <= ST_HOLD;
                count_r <= fill_nxt_s;
                slots_r <= slots_nxt_s;
            end else begin
                state_r <= state_r;
                count_r <= fill_nxt_s;
                slots_r <= slots_nxt_s;
            end
        end
    end

    // Output register. A load on the same edge as an output transfer replaces
    // the departing block, so out_valid stays high with no gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_block_r <= '0;
            out_dtype_r <= 3'd0;
`ifdef MX_PACK_FLUSH_EN
            out_count_r <= 6'd0;
`endif
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_block_r <= {scale_nxt_s, slots_nxt_s};
            out_dtype_r <= dtype_nxt_s;
`ifdef MX_PACK_FLUSH_EN
            out_count_r <= fill_nxt_s;
`endif
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_mx_block_packer.sv
// ---------------------------------------------------------------------------
// tb_mx_block_packer
//   Self-checking bench for mx_block_packer. The reference model is a list of
//   received elements plus a queue of completed blocks that are still owed to
//   the consumer.
//   - The queue length is the number of completed blocks still owed.
//   - out_valid is expected whenever that queue is non-empty.
//   - in_ready is expected whenever fewer than two blocks are owed: one in
//     the output register, one parked.
// ---------------------------------------------------------------------------
module tb_mx_block_packer;

    logic         clk;
    logic         rst_n;
    logic [2:0]   dtype_in;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_elem;
    logic [7:0]   in_scale;
    logic         out_valid;
    logic         out_ready;
    logic [263:0] out_block;
    logic [2:0]   out_dtype;
`ifdef MX_PACK_FLUSH_EN
    logic         flush;
    logic         flush_next;
    logic [5:0]   out_count;
`endif

    mx_block_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dtype_in  (dtype_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_elem   (in_elem),
        .in_scale  (in_scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .out_dtype (out_dtype)
`ifdef MX_PACK_FLUSH_EN
        ,
        .flush     (flush),
        .out_count (out_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [263:0] blk;
        logic [2:0]   dt;
        int           n;
    } blk_t;

    blk_t       owed_q[$];
    logic [7:0] part [0:31];
    int         part_n = 0;
    logic [7:0] part_scale;
    logic [2:0] part_dt;

    // Count one comparison and report it if it mismatches.
    task automatic check_eq(input string tag, input logic [263:0] got, input logic [263:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic blk_t make_blk();
        blk_t b;
        b.blk = '0;
        b.blk[263:256] = part_scale;
        for (int i = 0; i < part_n; i++) b.blk[i*8 +: 8] = part[i];
        b.dt = part_dt;
        b.n  = part_n;
        return b;
    endfunction

    // Check the DUT against the model, then advance the model over the
    // coming edge.
    task automatic check_and_update();
        bit   xfer;
        bit   acc;
        bit   done;
        blk_t nb;
        check_eq("out_valid", {263'd0, out_valid}, {263'd0, owed_q.size() > 0});
        check_eq("in_ready", {263'd0, in_ready}, {263'd0, owed_q.size() < 2});
        if (owed_q.size() > 0) begin
            check_eq("out_block", out_block, owed_q[0].blk);
            check_eq("out_dtype", {261'd0, out_dtype}, {261'd0, owed_q[0].dt});
`ifdef MX_PACK_FLUSH_EN
            check_eq("out_count", {258'd0, out_count}, 264'(owed_q[0].n));
`endif
        end
        xfer = (owed_q.size() > 0) && out_ready;
        acc  = in_valid && (owed_q.size() < 2);
        done = 1'b0;
        if (acc) begin
            if (part_n == 0) begin
                part_scale = in_scale;
                part_dt    = dtype_in;
            end
            part[part_n] = in_elem;
            part_n++;
        end
`ifdef MX_PACK_FLUSH_EN
        if (flush && (owed_q.size() < 2) && (part_n > 0)) done = 1'b1;
`endif
        if (part_n == 32) done = 1'b1;
        if (done) begin
            nb = make_blk();
            part_n = 0;
        end
        if (xfer) void'(owed_q.pop_front());
        if (done) owed_q.push_back(nb);
    endtask

    task automatic step(input logic v, input logic [7:0] e, input logic [7:0] s,
                        input logic [2:0] dt, input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_elem   = e;
        in_scale  = s;
        dtype_in  = dt;
        out_ready = ordy;
`ifdef MX_PACK_FLUSH_EN
        flush      = flush_next;
        flush_next = 1'b0;
`endif
        @(negedge clk);
        check_and_update();
    endtask

    logic [263:0] exp_blk;
    logic [7:0]   sc0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_elem   = 8'h00;
        in_scale  = 8'h00;
        dtype_in  = 3'd0;
        out_ready = 1'b0;
`ifdef MX_PACK_FLUSH_EN
        flush      = 1'b0;
        flush_next = 1'b0;
`endif
        #23;
        rst_n = 1'b1;
        #1;
        check_eq("rst_out_valid", {263'd0, out_valid}, 264'd0);
        check_eq("rst_out_block", out_block, 264'd0);
        check_eq("rst_out_dtype", {261'd0, out_dtype}, 264'd0);
        check_eq("rst_in_ready", {263'd0, in_ready}, 264'd1);

        // Basic packing: elements 0..31, scale AA, consumer always ready.
        for (int i = 0; i < 32; i++) step(1'b1, 8'(i), 8'hAA, 3'd1, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        exp_blk = '0;
        exp_blk[263:256] = 8'hAA;
        for (int i = 0; i < 32; i++) exp_blk[i*8 +: 8] = 8'(i);
        check_eq("basic_blk", out_block, exp_blk);
        check_eq("basic_valid", {263'd0, out_valid}, 264'd1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // Scale and dtype are sampled with element 0 only.
        sc0 = 8'($urandom);
        for (int i = 0; i < 32; i++)
            step(1'b1, 8'($urandom), (i == 0) ? sc0 : 8'($urandom), (i == 0) ? 3'd2 : 3'd5, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        check_eq("dtype_sample", {261'd0, out_dtype}, 264'd2);
        check_eq("scale_sample", {256'd0, out_block[263:256]}, {256'd0, sc0});
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // Backpressure: two blocks stream in with the consumer stalled.
        for (int i = 0; i < 70; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
        check_eq("hold_in_ready", {263'd0, in_ready}, 264'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);

        // Back-to-back throughput: 96 elements, no bubbles.
        for (int i = 0; i < 96; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

        // Reset mid-fill with a block still waiting in the output register.
        for (int i = 0; i < 32; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0);
        @(posedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", {263'd0, out_valid}, 264'd0);
        check_eq("async_rst_block", out_block, 264'd0);
        part_n = 0;
        owed_q.delete();
        #4;
        rst_n = 1'b1;
        for (int i = 0; i < 33; i++) step(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);

`ifdef MX_PACK_FLUSH_EN
        // Early flush after five elements; then a flush with nothing pending.
        for (int i = 0; i < 5; i++) begin
            if (i == 4) flush_next = 1'b1;
            step(1'b1, 8'h11 + 8'(i), 8'h3C, 3'd4, 1'b1);
        end
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
        exp_blk = '0;
        exp_blk[263:256] = 8'h3C;
        for (int i = 0; i < 5; i++) exp_blk[i*8 +: 8] = 8'h11 + 8'(i);
        check_eq("flush_blk", out_block, exp_blk);
        check_eq("flush_count", {258'd0, out_count}, 264'd5);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        flush_next = 1'b1;
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
        step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
`endif

        // Randomized traffic with random stalls on both sides.
        for (int i = 0; i < 800; i++) begin
`ifdef MX_PACK_FLUSH_EN
            flush_next = ($urandom_range(0, 19) == 0);
`endif
            step($urandom_range(0, 9) < 7, 8'($urandom), 8'($urandom), 3'($urandom),
                 $urandom_range(0, 9) < 6);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mx_block_packer.md
Name: mx_block_packer

Overview:
- Upstream feeder for mx_alu_wrapper.
- Accepts a stream of 8-bit MXFP8 elements plus a per-block E8M0 shared scale over a valid/ready handshake.
- Assembles them into one 264-bit MX block (32 elements of 8 bits, plus an 8-bit scale) and presents it on a registered valid/ready output that drives vec_in_a/vec_in_b.
- Provides one assembly register plus one output register, so a new block can be filled while the previous one waits downstream.

Parameters:
- d, 8, element width in bits
- k, 32, elements per block
- w, 8, scale width in bits
- size, k*d+w (264), output block width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dtype_in  in  3  element format code; sampled with element 0 of each block
- in_valid  in  1  element/scale valid
- in_ready  out  1  packer can accept an element this cycle
- in_elem  in  d  element payload
- in_scale  in  w  shared scale; sampled only with element 0
- out_valid  out  1  out_block holds a complete block
- out_ready  in  1  downstream accepts the block
- out_block  out  size  packed block
- out_dtype  out  3  dtype of out_block

Behaviour:
- Output packing:
  - out_block[size-1:size-w] = scale
  - element i occupies out_block[d*i+d-1:d*i]
  - Element 0 is the first element accepted; this matches mxfp8_block {scale, elements[k-1:0]}.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_block and out_dtype hold stable.
  - in_valid is not required to be continuous; idle cycles leave state unchanged.
- State machine:
  - FILL: count 0..k-1; in_ready=1.
    - Each input transfer writes in_elem into slot[count] and increments count.
    - At count==0, the transfer also latches in_scale and dtype_in.
  - Accepting element k-1:
    - If the output register is free this cycle (out_valid==0, or an output transfer occurs this cycle), the completed block loads the output register on this edge: out_valid=1 next cycle, count=0, remain in FILL.
    - Otherwise, go to HOLD.
  - HOLD: in_ready=0.
    - When the output register frees (same freeing condition as above), load it, set count=0, go to FILL.
    - This costs one input bubble cycle.
- Latency and throughput:
  - out_valid rises the cycle after the 32nd element is accepted.
  - With out_ready held high, sustained throughput is 1 element per cycle, 1 block per 32 cycles, with no bubbles.
- Reset (async assert, sync release):
  - out_valid=0, out_block=0, out_dtype=0, count=0, state=FILL.
  - in_ready=1 once released.
  - A partial block in progress is discarded.
- Simultaneous events: the output transfer and the load of a new block on the same edge are legal. The new block replaces the old one with no gap in out_valid.
- Count is 6 bits and never exceeds k.

Optional Feature:
- Macro: MX_PACK_FLUSH_EN.
- When defined, the block adds:
  - Input port flush (1 bit): a single-cycle request.
  - Output port out_count (6 bits): number of real elements in out_block.
- Flush behaviour:
  - A flush in FILL with count>0 completes the block early. Unfilled slots are +0.0 (8'h00), and out_count=count.
  - Same-cycle output-free rules as a normal completion apply; if the output register is busy, go to HOLD.
  - If an element is accepted on the same cycle as the flush, that element is included first.
  - A flush with count==0 and no accept, or a flush in HOLD, is ignored.
  - Full blocks report out_count=32.
- When undefined: neither port exists, and only full 32-element blocks are produced.

Test Plan:
1. Basic packing: scale 8'hAA, elements i=0..31 with value 8'h00+i, out_ready=1 → one cycle after the last accept, out_valid=1 and out_block = {8'hAA, 8'h1F, ..., 8'h01, 8'h00}; out_valid drops the next cycle.
2. Scale/dtype sampling: in_scale changes every cycle, dtype_in=3'd2 at element 0 then 3'd5 → out_block scale = value at element 0, out_dtype=2.
3. Backpressure: out_ready=0 while two full blocks stream in:
   - block 1 is held stable;
   - after the 32nd element of block 2, in_ready=0 (HOLD);
   - raising out_ready gives block 1, then block 2 one cycle later;
   - in_ready returns the cycle after block 2 loads.
4. Back-to-back throughput: 96 elements, in_valid and out_ready always 1 → three blocks, out_valid pulses 32 cycles apart, in_ready never 0.
5. Reset mid-fill: rst_n low after 10 elements → out_valid=0 immediately (async); the next 32 elements form a clean block with element 0 equal to the first post-reset element.
6. (MX_PACK_FLUSH_EN) Early flush: flush after 5 elements 8'h11..8'h15 → out_count=5, slots 0..4 = 8'h11..8'h15, slots 5..31 = 8'h00.
